llq_enq_ctrl: RTL and testbench

Enqueue-side controller for the shared linked-list queue store (NUM_Q queues threaded through one NUM_SLOT-entry next-pointer table). It allocates free slots, appends them to the tail of the addressed queue, and produces the next-table and head-table writes consumed by the downstream head/next sampling stage. It also reclaims slots released by the pop side and keeps per-queue occupancy.

---
 rtl/llq_pkg.sv | 12 +
 rtl/llq_enq_ctrl_if.sv | 40 ++++
 rtl/llq_free_alloc.sv | 58 +++++
 rtl/llq_enq_ctrl.sv | 98 +++++++++
 tb/tb_llq_enq_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/llq_pkg.sv
// llq_pkg: shared defaults and types for the linked-list queue enqueue slice.
//   DEF_NUM_Q / DEF_NUM_SLOT : default queue count and shared-store depth
//   qid_t / slot_t / cnt_t   : queue id, slot pointer and occupancy types at the defaults
package llq_pkg;
  localparam int DEF_NUM_Q    = 4;
  localparam int DEF_NUM_SLOT = 4;

  typedef logic [$clog2(DEF_NUM_Q)-1:0]    qid_t;
  typedef logic [$clog2(DEF_NUM_SLOT)-1:0] slot_t;
  // Occupancy needs one extra bit so a queue holding every slot is representable.
  typedef logic [$clog2(DEF_NUM_SLOT):0]   cnt_t;
endpackage

// File: rtl/llq_enq_ctrl_if.sv
// llq_enq_ctrl_if: push/release handshake plus the head/next table write bus.
//   push_*  : enqueue request, ready and allocated slot
//   rel_*   : slot released by the pop side
//   link_*  : next[link_addr] = link_data write
//   head_*  : head[head_qid] = head_data write
//   master  : side that issues pushes/releases and consumes table writes
//   slave   : the enqueue controller
interface llq_enq_ctrl_if import llq_pkg::*; #(
  parameter int NUM_Q    = DEF_NUM_Q,
  parameter int NUM_SLOT = DEF_NUM_SLOT
) ();
  localparam int QW = $clog2(NUM_Q);
  localparam int PW = $clog2(NUM_SLOT);

  logic          push_valid;
  logic [QW-1:0] push_qid;
  logic          push_ready;
  logic [PW-1:0] push_slot;
  logic          rel_valid;
  logic [PW-1:0] rel_slot;
  logic [QW-1:0] rel_qid;
  logic          link_we;
  logic [PW-1:0] link_addr;
  logic [PW-1:0] link_data;
  logic          head_we;
  logic [QW-1:0] head_qid;
  logic [PW-1:0] head_data;

  modport master (
    output push_valid, push_qid, rel_valid, rel_slot, rel_qid,
    input  push_ready, push_slot, link_we, link_addr, link_data,
           head_we, head_qid, head_data
  );

  modport slave (
    input  push_valid, push_qid, rel_valid, rel_slot, rel_qid,
    output push_ready, push_slot, link_we, link_addr, link_data,
           head_we, head_qid, head_data
  );
endinterface

// File: rtl/llq_free_alloc.sv
// llq_free_alloc: free-slot bitmap with lowest-index allocation.
//   clk, reset  : clock, synchronous active-high reset
//   alloc_en    : consume alloc_slot this cycle
//   alloc_ok    : at least one slot free (from registers only)
//   alloc_slot  : lowest free slot index (0 when none)
//   rel_valid   : raw release request, used for double-free detection
//   rel_en      : qualified release, sets free[rel_slot]
//   rel_slot    : slot being released
//   dbl_free    : release targets a slot that is already free
//   free_cnt    : registered number of free slots
module llq_free_alloc import llq_pkg::*; #(
  parameter  int NUM_SLOT = DEF_NUM_SLOT,
  localparam int PW       = $clog2(NUM_SLOT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alloc_en,
  output logic          alloc_ok,
  output logic [PW-1:0] alloc_slot,
  input  logic          rel_valid,
  input  logic          rel_en,
  input  logic [PW-1:0] rel_slot,
  output logic          dbl_free,
  output logic [PW:0]   free_cnt
);
  logic [NUM_SLOT-1:0] free_q, free_d;
  logic [PW:0]         cnt_d;

  // Scan from the top down so the last hit is the lowest set bit.
  always_comb begin
    alloc_slot = '0;
    for (int i = NUM_SLOT-1; i >= 0; i--)
      if (free_q[i]) alloc_slot = PW'(i);
  end

  assign alloc_ok = |free_q;
  assign dbl_free = rel_valid & free_q[rel_slot];

  // A released slot only becomes visible to the encoder after the edge.
  always_comb begin
    free_d = free_q;
    if (alloc_en) free_d[alloc_slot] = 1'b0;
    if (rel_en)   free_d[rel_slot]   = 1'b1;
    cnt_d = '0;
    for (int i = 0; i < NUM_SLOT; i++)
      cnt_d = cnt_d + (PW+1)'(free_d[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      free_q   <= '1;
      free_cnt <= (PW+1)'(NUM_SLOT);
    end else begin
      free_q   <= free_d;
      free_cnt <= cnt_d;
    end
  end
endmodule

// File: rtl/llq_enq_ctrl.sv
// llq_enq_ctrl: enqueue-side controller for the shared linked-list queue store.
// Allocates a free slot per accepted push, appends it to the addressed queue's
// tail and issues either a head-table write (queue was empty) or a next-table
// link write one cycle later. Reclaims released slots and tracks occupancy.
//   clk, reset : clock, synchronous active-high reset
//   bus        : push/release handshake and head/link write outputs (slave)
//   q_empty    : registered per-queue empty flags
//   free_cnt   : registered free-slot count
//   err        : sticky protocol error (bad release), cleared only by reset
module llq_enq_ctrl import llq_pkg::*; #(
  parameter  int NUM_Q    = DEF_NUM_Q,
  parameter  int NUM_SLOT = DEF_NUM_SLOT,
  localparam int QW       = $clog2(NUM_Q),
  localparam int PW       = $clog2(NUM_SLOT)
) (
  input  logic               clk,
  input  logic               reset,
  llq_enq_ctrl_if.slave      bus,
  output logic [NUM_Q-1:0]   q_empty,
  output logic [PW:0]        free_cnt,
  output logic               err
);
  logic [NUM_Q-1:0][PW-1:0] tail_q;
  logic [NUM_Q-1:0][PW:0]   cnt_q, cnt_d;
  logic                     accept, rel_ok, rel_bad, dbl_free, same_q;
  logic [PW:0]              ec;
  logic                     alloc_ok;
  logic [PW-1:0]            alloc_slot;

  logic          link_we_r, head_we_r;
  logic [PW-1:0] link_addr_r, link_data_r, head_data_r;
  logic [QW-1:0] head_qid_r;

  llq_free_alloc #(.NUM_SLOT(NUM_SLOT)) u_free (
    .clk        (clk),
    .reset      (reset),
    .alloc_en   (accept),
    .alloc_ok   (alloc_ok),
    .alloc_slot (alloc_slot),
    .rel_valid  (bus.rel_valid),
    .rel_en     (rel_ok),
    .rel_slot   (bus.rel_slot),
    .dbl_free   (dbl_free),
    .free_cnt   (free_cnt)
  );

  assign bus.push_ready = alloc_ok;
  assign bus.push_slot  = alloc_slot;
  assign accept         = bus.push_valid & alloc_ok;

  always_comb begin
    // A bad release is dropped entirely, so it must not affect ec either.
    rel_bad = bus.rel_valid & ((cnt_q[bus.rel_qid] == '0) | dbl_free);
    rel_ok  = bus.rel_valid & ~rel_bad;
    same_q  = rel_ok & (bus.rel_qid == bus.push_qid);
    // Releasing the sole entry while pushing the same queue makes it empty.
    ec      = cnt_q[bus.push_qid] - (PW+1)'(same_q);
    cnt_d   = cnt_q;
    if (accept) cnt_d[bus.push_qid] = cnt_d[bus.push_qid] + (PW+1)'(1);
    if (rel_ok) cnt_d[bus.rel_qid]  = cnt_d[bus.rel_qid]  - (PW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tail_q      <= '0;
      cnt_q       <= '0;
      err         <= 1'b0;
      q_empty     <= '1;
      link_we_r   <= 1'b0;
      head_we_r   <= 1'b0;
      link_addr_r <= '0;
      link_data_r <= '0;
      head_qid_r  <= '0;
      head_data_r <= '0;
    end else begin
      cnt_q     <= cnt_d;
      err       <= err | rel_bad;
      link_we_r <= accept & (ec != '0);
      head_we_r <= accept & (ec == '0);
      for (int i = 0; i < NUM_Q; i++)
        q_empty[i] <= (cnt_d[i] == '0);
      if (accept) begin
        tail_q[bus.push_qid] <= alloc_slot;
        link_addr_r          <= tail_q[bus.push_qid];
        link_data_r          <= alloc_slot;
        head_qid_r           <= bus.push_qid;
        head_data_r          <= alloc_slot;
      end
    end
  end

  assign bus.link_we   = link_we_r;
  assign bus.link_addr = link_addr_r;
  assign bus.link_data = link_data_r;
  assign bus.head_we   = head_we_r;
  assign bus.head_qid  = head_qid_r;
  assign bus.head_data = head_data_r;
endmodule

// File: tb/tb_llq_enq_ctrl.sv
module tb_llq_enq_ctrl;
  import llq_pkg::*;
  localparam int NQ = DEF_NUM_Q;
  localparam int NS = DEF_NUM_SLOT;
  localparam int PW = $clog2(NS);

  logic          clk = 1'b0;
  logic          reset;
  logic [NQ-1:0] q_empty;
  logic [PW:0]   free_cnt;
  logic          err;

  llq_enq_ctrl_if #(.NUM_Q(NQ), .NUM_SLOT(NS)) bus();

  llq_enq_ctrl #(.NUM_Q(NQ), .NUM_SLOT(NS)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .q_empty  (q_empty),
    .free_cnt (free_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: each queue is an ordered list of slots, plus a free set.
  int      mq[NQ][$];
  bit      mfree[NS];
  bit      merr;
  bit      e_link_we, e_head_we;
  int      e_link_addr, e_link_data, e_head_qid, e_head_data;
  bit      m_ready;
  int      m_slot;
  logic          o_ready;
  logic [PW-1:0] o_slot;

  function automatic int m_free_cnt();
    int n = 0;
    for (int i = 0; i < NS; i++) n += mfree[i];
    return n;
  endfunction

  function automatic logic [NQ-1:0] m_empty();
    logic [NQ-1:0] e;
    for (int q = 0; q < NQ; q++) e[q] = (mq[q].size() == 0);
    return e;
  endfunction

  task automatic model_reset();
    for (int q = 0; q < NQ; q++) mq[q].delete();
    for (int i = 0; i < NS; i++) mfree[i] = 1'b1;
    merr = 0; e_link_we = 0; e_head_we = 0;
  endtask

  task automatic idle_inputs();
    bus.push_valid = 0; bus.push_qid = '0;
    bus.rel_valid  = 0; bus.rel_slot = '0; bus.rel_qid = '0;
  endtask

  task automatic do_reset();
    reset = 1; idle_inputs();
    @(posedge clk); #1;
    reset = 0; model_reset();
  endtask

  // Drive one cycle, sample push_ready/push_slot before the edge, advance the model.
  task automatic cycle(input bit pv, input int pq, input bit rv, input int rs, input int rq);
    bit rel_ok;
    int idx;
    bus.push_valid = pv; bus.push_qid = qid_t'(pq);
    bus.rel_valid  = rv; bus.rel_slot = slot_t'(rs); bus.rel_qid = qid_t'(rq);
    #1;
    o_ready = bus.push_ready; o_slot = bus.push_slot;
    m_ready = 0; m_slot = 0;
    for (int i = NS-1; i >= 0; i--) if (mfree[i]) begin m_ready = 1; m_slot = i; end
    rel_ok = rv && (mq[rq].size() != 0) && !mfree[rs];
    if (rv && !rel_ok) merr = 1;
    if (rel_ok) begin
      idx = 0;
      for (int k = 0; k < mq[rq].size(); k++) if (mq[rq][k] == rs) idx = k;
      mq[rq].delete(idx);
    end
    e_link_we = 0; e_head_we = 0;
    if (pv && m_ready) begin
      if (mq[pq].size() == 0) begin
        e_head_we = 1; e_head_qid = pq; e_head_data = m_slot;
      end else begin
        e_link_we = 1; e_link_addr = mq[pq][$]; e_link_data = m_slot;
      end
      mq[pq].push_back(m_slot);
      mfree[m_slot] = 0;
    end
    if (rel_ok) mfree[rs] = 1;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    @(posedge clk); @(posedge clk); #1;
    reset = 0; model_reset();
    checks++; if (bus.push_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.push_ready); end
    checks++; if (bus.push_slot !== '0) begin errors++; $display("FAIL rst_slot: got %0d want 0", bus.push_slot); end
    checks++; if (bus.link_we !== 1'b0 || bus.head_we !== 1'b0) begin errors++; $display("FAIL rst_we: got link=%b head=%b want 0 0", bus.link_we, bus.head_we); end
    checks++; if ({bus.link_addr, bus.link_data, bus.head_qid, bus.head_data} !== '0) begin errors++; $display("FAIL rst_bus: got %h want 0", {bus.link_addr, bus.link_data, bus.head_qid, bus.head_data}); end
    checks++; if (q_empty !== '1) begin errors++; $display("FAIL rst_q_empty: got %b want all ones", q_empty); end
    checks++; if (free_cnt !== (PW+1)'(NS)) begin errors++; $display("FAIL rst_free_cnt: got %0d want %0d", free_cnt, NS); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < NS; i++) begin
      cycle(1, 0, 0, 0, 0);
      checks++; if (o_ready !== 1'b1 || o_slot !== PW'(i)) begin errors++; $display("FAIL fill_alloc%0d: got ready=%b slot=%0d want 1 %0d", i, o_ready, o_slot, i); end
      if (i == 0) begin
        checks++; if (bus.head_we !== 1'b1 || bus.link_we !== 1'b0 || bus.head_qid !== '0 || bus.head_data !== '0)
          begin errors++; $display("FAIL fill_head: got hwe=%b lwe=%b q=%0d d=%0d want 1 0 0 0", bus.head_we, bus.link_we, bus.head_qid, bus.head_data); end
      end else begin
        checks++; if (bus.link_we !== 1'b1 || bus.head_we !== 1'b0 || bus.link_addr !== PW'(i-1) || bus.link_data !== PW'(i))
          begin errors++; $display("FAIL fill_link%0d: got lwe=%b hwe=%b %0d->%0d want 1 0 %0d->%0d", i, bus.link_we, bus.head_we, bus.link_addr, bus.link_data, i-1, i); end
      end
    end
    checks++; if (bus.push_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready: got %b want 0", bus.push_ready); end
    checks++; if (free_cnt !== '0) begin errors++; $display("FAIL fill_free_cnt: got %0d want 0", free_cnt); end
  endtask

  task automatic test_refill();
    cycle(1, 1, 1, 2, 0);  // push held while full, release slot 2 of q0
    checks++; if (o_ready !== 1'b0 || bus.head_we !== 1'b0 || bus.link_we !== 1'b0)
      begin errors++; $display("FAIL refill_stall: got ready=%b hwe=%b lwe=%b want 0 0 0", o_ready, bus.head_we, bus.link_we); end
    checks++; if (bus.push_ready !== 1'b1 || bus.push_slot !== PW'(2))
      begin errors++; $display("FAIL refill_ready: got ready=%b slot=%0d want 1 2", bus.push_ready, bus.push_slot); end
    cycle(1, 1, 0, 0, 0);
    checks++; if (bus.head_we !== 1'b1 || bus.link_we !== 1'b0 || bus.head_qid !== 2'(1) || bus.head_data !== PW'(2))
      begin errors++; $display("FAIL refill_head: got hwe=%b lwe=%b q=%0d d=%0d want 1 0 1 2", bus.head_we, bus.link_we, bus.head_qid, bus.head_data); end
    checks++; if (q_empty !== 4'b1100) begin errors++; $display("FAIL refill_q_empty: got %b want 1100", q_empty); end
    checks++; if (free_cnt !== '0) begin errors++; $display("FAIL refill_free_cnt: got %0d want 0", free_cnt); end
  endtask

  task automatic test_same_q_push_rel();
    do_reset();
    cycle(1, 0, 0, 0, 0);  // slot 0 -> q0
    cycle(1, 3, 0, 0, 0);  // slot 1 -> q3
    cycle(1, 3, 1, 1, 3);  // push q3 while its only entry leaves
    checks++; if (bus.head_we !== 1'b1 || bus.link_we !== 1'b0 || bus.head_qid !== 2'(3) || bus.head_data !== PW'(2))
      begin errors++; $display("FAIL sameq_head: got hwe=%b lwe=%b q=%0d d=%0d want 1 0 3 2", bus.head_we, bus.link_we, bus.head_qid, bus.head_data); end
    checks++; if (q_empty !== 4'b0110) begin errors++; $display("FAIL sameq_q_empty: got %b want 0110", q_empty); end
    cycle(0, 0, 1, 2, 3);  // count[q3] must have been exactly one
    checks++; if (q_empty !== 4'b1110 || err !== 1'b0) begin errors++; $display("FAIL sameq_count: got q_empty=%b err=%b want 1110 0", q_empty, err); end
    checks++; if (free_cnt !== (PW+1)'(3)) begin errors++; $display("FAIL sameq_free_cnt: got %0d want 3", free_cnt); end
  endtask

  task automatic test_errors();
    do_reset();
    cycle(1, 0, 0, 0, 0);  // slot 0 -> q0
    cycle(0, 0, 1, 0, 2);  // release on empty q2
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_empty_q: got %b want 1", err); end
    checks++; if (free_cnt !== (PW+1)'(3) || q_empty !== 4'b1110) begin errors++; $display("FAIL err_empty_drop: got free=%0d q_empty=%b want 3 1110", free_cnt, q_empty); end
    cycle(0, 0, 1, 3, 0);  // slot 3 already free
    checks++; if (err !== 1'b1 || free_cnt !== (PW+1)'(3) || q_empty !== 4'b1110)
      begin errors++; $display("FAIL err_dbl_free: got err=%b free=%0d q_empty=%b want 1 3 1110", err, free_cnt, q_empty); end
    cycle(0, 0, 1, 0, 0);  // legal release still works, err stays
    checks++; if (err !== 1'b1 || free_cnt !== (PW+1)'(4) || q_empty !== 4'b1111)
      begin errors++; $display("FAIL err_sticky: got err=%b free=%0d q_empty=%b want 1 4 1111", err, free_cnt, q_empty); end
    checks++; if (bus.push_slot !== '0) begin errors++; $display("FAIL err_alloc: got %0d want 0", bus.push_slot); end
  endtask

  task automatic test_random();
    bit pv, rv;
    int pq, rq, rs;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      pv = ($urandom_range(0, 3) != 0);
      pq = $urandom_range(0, 1);
      rq = ($urandom_range(0, 3) == 0) ? pq : (1 - pq);
      if ($urandom_range(0, 7) == 0) rq = $urandom_range(2, NQ-1);
      rv = $urandom_range(0, 1) && (mq[rq].size() != 0);
      rs = rv ? mq[rq][0] : 0;
      cycle(pv, pq, rv, rs, rq);
      checks++; if (o_ready !== m_ready || (m_ready && o_slot !== PW'(m_slot)))
        begin errors++; $display("FAIL rnd_alloc@%0d: got %b/%0d want %b/%0d", n, o_ready, o_slot, m_ready, m_slot); end
      checks++; if (bus.link_we !== e_link_we || bus.head_we !== e_head_we)
        begin errors++; $display("FAIL rnd_we@%0d: got l=%b h=%b want l=%b h=%b", n, bus.link_we, bus.head_we, e_link_we, e_head_we); end
      if (e_link_we) begin
        checks++; if (bus.link_addr !== PW'(e_link_addr) || bus.link_data !== PW'(e_link_data))
          begin errors++; $display("FAIL rnd_link@%0d: got %0d->%0d want %0d->%0d", n, bus.link_addr, bus.link_data, e_link_addr, e_link_data); end
      end
      if (e_head_we) begin
        checks++; if (bus.head_qid !== 2'(e_head_qid) || bus.head_data !== PW'(e_head_data))
          begin errors++; $display("FAIL rnd_head@%0d: got q%0d=%0d want q%0d=%0d", n, bus.head_qid, bus.head_data, e_head_qid, e_head_data); end
      end
      checks++; if (free_cnt !== (PW+1)'(m_free_cnt()) || q_empty !== m_empty() || err !== merr)
        begin errors++; $display("FAIL rnd_state@%0d: got free=%0d empty=%b err=%b want %0d %b %b", n, free_cnt, q_empty, err, m_free_cnt(), m_empty(), merr); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(0, 0, 1, 0, 1);  // sets err
    cycle(1, 2, 0, 0, 0);  // accept -> head pulse now visible
    bus.push_valid = 1; bus.push_qid = qid_t'(2);
    reset = 1;
    @(posedge clk); #1;
    checks++; if (bus.link_we !== 1'b0 || bus.head_we !== 1'b0)
      begin errors++; $display("FAIL mid_rst_we: got l=%b h=%b want 0 0", bus.link_we, bus.head_we); end
    checks++; if (bus.push_ready !== 1'b1 || bus.push_slot !== '0 || free_cnt !== (PW+1)'(NS) || q_empty !== '1 || err !== 1'b0)
      begin errors++; $display("FAIL mid_rst_state: got rdy=%b slot=%0d free=%0d empty=%b err=%b want 1 0 %0d 1111 0", bus.push_ready, bus.push_slot, free_cnt, q_empty, err, NS); end
    reset = 0; idle_inputs(); model_reset();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_refill();
    test_same_q_push_rel();
    test_errors();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
